alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_skid_buf.sv | 77 +++++++
 rtl/alu_operand_stage.sv | 101 ++++++++++
 tb/tb_alu_operand_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: default lane geometry and mode encoding.
package alu_pkg;

  localparam int   LANES_DEF   = 2;
  localparam int   LANE_W_DEF  = 32;
  localparam logic MODE_MERGED = 1'b0;
  localparam logic MODE_FULL   = 1'b1;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry (main + skid) valid/ready buffer with registered outputs and registered ready.
// The main entry drives the outputs directly; the skid entry absorbs one beat under backpressure.
module alu_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] data_o
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept_s;
  logic         drain_s;

  // Occupancy and data movement; ready for next cycle is derived from next occupancy
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    accept_s   = in_valid_i && rdy_q;
    drain_s    = main_vld_q && out_ready_i;
    if (drain_s) begin
      if (skid_vld_q) begin
        // full: no accept can coincide because rdy_q is low
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept_s) begin
        main_d = data_i;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept_s) begin
      if (main_vld_q) begin
        skid_d     = data_i;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = data_i;
        main_vld_d = 1'b1;
      end
    end else begin
      main_vld_d = main_vld_q;
    end
    rdy_d = !(main_vld_d && skid_vld_d);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_vld_q;
  assign data_o      = main_q;

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand preparation: per-lane thread A/B merge with immediate replication, then a skid buffer.
// Optional stall counter enabled by defining ALU_OPSTAGE_PERF_EN.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter  int LANES  = LANES_DEF,
  parameter  int LANE_W = LANE_W_DEF,
  localparam int DATA_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs1_a,
  input  logic [DATA_W-1:0] rs2_a,
  input  logic [DATA_W-1:0] rs1_b,
  input  logic [DATA_W-1:0] rs2_b,
  input  logic              mode,
  input  logic [LANES-1:0]  lane_sel,
  input  logic              alu_src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [LANES-1:0]  out_lane_sel,
  output logic [31:0]       perf_stall_cnt
);

  localparam int PAY_W = 2 * DATA_W + LANES;

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [LANES-1:0]  sel_s;
  logic [PAY_W-1:0]  pay_in_s;
  logic [PAY_W-1:0]  pay_out_s;

  // Lane merge: B-selected lanes take thread B, op_b optionally the replicated lane-0 immediate
  always_comb begin
    op_a_s = rs1_a;
    op_b_s = rs2_a;
    sel_s  = '0;
    if (mode == MODE_MERGED) begin
      sel_s = lane_sel;
      for (int i = 0; i < LANES; i++) begin
        op_a_s[i*LANE_W +: LANE_W] = lane_sel[i] ? rs1_b[i*LANE_W +: LANE_W]
                                                 : rs1_a[i*LANE_W +: LANE_W];
        op_b_s[i*LANE_W +: LANE_W] = !lane_sel[i] ? rs2_a[i*LANE_W +: LANE_W]
                                   : (alu_src_b ? rs2_b[LANE_W-1:0]
                                                : rs2_b[i*LANE_W +: LANE_W]);
      end
    end else begin
      sel_s = '0;
    end
  end

  assign pay_in_s = {sel_s, op_b_s, op_a_s};

  alu_skid_buf #(
    .W (PAY_W)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (pay_in_s),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (pay_out_s)
  );

  assign op_a         = pay_out_s[DATA_W-1:0];
  assign op_b         = pay_out_s[2*DATA_W-1:DATA_W];
  assign out_lane_sel = pay_out_s[PAY_W-1:2*DATA_W];

`ifdef ALU_OPSTAGE_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles a valid beat is held back
  always_comb begin
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vectors, backpressure, reset and a
// scoreboard that follows every accepted beat to its output.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mode, alu_src_b, out_valid, out_ready;
  logic [1:0]  lane_sel, out_lane_sel;
  logic [63:0] rs1_a, rs2_a, rs1_b, rs2_b, op_a, op_b;
  logic [31:0] perf_stall_cnt;

  logic        in_valid2, in_ready2, mode2, alu_src_b2, out_valid2, out_ready2;
  logic [3:0]  lane_sel2, out_lane_sel2;
  logic [63:0] rs1_a2, rs2_a2, rs1_b2, rs2_b2, op_a2, op_b2;
  logic [31:0] perf_stall_cnt2;

  int errors = 0;
  int checks = 0;
  int stall_model = 0;
  logic [129:0] sb[$];

  always #5 clk = ~clk;

  alu_operand_stage #(.LANES(2), .LANE_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_a(rs1_a), .rs2_a(rs2_a), .rs1_b(rs1_b), .rs2_b(rs2_b),
    .mode(mode), .lane_sel(lane_sel), .alu_src_b(alu_src_b),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .out_lane_sel(out_lane_sel), .perf_stall_cnt(perf_stall_cnt)
  );

  alu_operand_stage #(.LANES(4), .LANE_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .rs1_a(rs1_a2), .rs2_a(rs2_a2), .rs1_b(rs1_b2), .rs2_b(rs2_b2),
    .mode(mode2), .lane_sel(lane_sel2), .alu_src_b(alu_src_b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .op_a(op_a2), .op_b(op_b2),
    .out_lane_sel(out_lane_sel2), .perf_stall_cnt(perf_stall_cnt2)
  );

  // Reference: build {lane_sel_out, op_b, op_a} lane by lane for the 2x32 configuration
  function automatic logic [129:0] model(input logic m, input logic [1:0] ls, input logic imm,
                                         input logic [63:0] r1a, input logic [63:0] r2a,
                                         input logic [63:0] r1b, input logic [63:0] r2b);
    logic [31:0] a0, a1, b0, b1;
    a0 = r1a[31:0];  a1 = r1a[63:32];
    b0 = r2a[31:0];  b1 = r2a[63:32];
    if (m == 1'b1) return {2'b00, b1, b0, a1, a0};
    if (ls[0]) begin a0 = r1b[31:0];  b0 = r2b[31:0]; end
    if (ls[1]) begin a1 = r1b[63:32]; b1 = imm ? r2b[31:0] : r2b[63:32]; end
    return {ls, b1, b0, a1, a0};
  endfunction

  logic [129:0] exp_v;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      stall_model = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: unexpected beat op_a=%h op_b=%h", op_a, op_b);
        end else begin
          exp_v = sb.pop_front();
          if ({out_lane_sel, op_b, op_a} !== exp_v) begin
            errors++;
            $display("FAIL sb_beat: got sel=%b a=%h b=%h want sel=%b a=%h b=%h",
                     out_lane_sel, op_a, op_b, exp_v[129:128], exp_v[63:0], exp_v[127:64]);
          end
        end
      end
      if (out_valid && !out_ready) stall_model++;
      if (in_valid && in_ready)
        sb.push_back(model(mode, lane_sel, alu_src_b, rs1_a, rs2_a, rs1_b, rs2_b));
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== 64'd0 || op_b !== 64'd0 ||
        out_lane_sel !== 2'b00 || perf_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b a=%h b=%h sel=%b cnt=%0d want 0 1 0 0 0 0",
               out_valid, in_ready, op_a, op_b, out_lane_sel, perf_stall_cnt);
    end
  endtask

  task automatic test_full_mode();
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; mode = 1'b1; lane_sel = 2'b11; alu_src_b = 1'b1;
    rs1_a = 64'h1111_2222_3333_4444; rs2_a = 64'h5555_6666_7777_8888;
    rs1_b = 64'hDEAD_BEEF_DEAD_BEEF; rs2_b = 64'hFEED_FACE_FEED_FACE;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || op_a !== 64'h1111_2222_3333_4444 ||
        op_b !== 64'h5555_6666_7777_8888 || out_lane_sel !== 2'b00) begin
      errors++;
      $display("FAIL full_mode: ov=%b a=%h b=%h sel=%b", out_valid, op_a, op_b, out_lane_sel);
    end
  endtask

  task automatic test_merge();
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0; lane_sel = 2'b10; alu_src_b = 1'b0;
    rs1_a = 64'h1111_2222_3333_4444; rs2_a = 64'h5555_6666_7777_8888;
    rs1_b = 64'hAAAA_AAAA_0000_0000; rs2_b = 64'hBBBB_BBBB_CCCC_CCCC;
    @(posedge clk); #1 alu_src_b = 1'b1;
    @(negedge clk);
    checks++;
    if (op_a !== 64'hAAAA_AAAA_3333_4444 || op_b !== 64'hBBBB_BBBB_7777_8888 ||
        out_lane_sel !== 2'b10) begin
      errors++;
      $display("FAIL merge_reg: a=%h b=%h sel=%b", op_a, op_b, out_lane_sel);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || op_a !== 64'hAAAA_AAAA_3333_4444 ||
        op_b !== 64'hCCCC_CCCC_7777_8888) begin
      errors++;
      $display("FAIL merge_imm: ov=%b a=%h b=%h", out_valid, op_a, op_b);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b1;
    rs1_a = 64'h0000_0000_0000_0010; rs2_a = 64'h0000_0000_0000_0011;
    @(posedge clk); #1 rs1_a = 64'h0000_0000_0000_0020;
    @(posedge clk); #1 rs1_a = 64'h0000_0000_0000_0030;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || op_a !== 64'h10) begin
      errors++;
      $display("FAIL bp_full: ir=%b ov=%b a=%h want 0 1 10", in_ready, out_valid, op_a);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || op_a !== 64'h10 || op_b !== 64'h11) begin
        errors++;
        $display("FAIL bp_hold: ir=%b a=%h b=%h", in_ready, op_a, op_b);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || op_a !== 64'h20) begin
      errors++;
      $display("FAIL bp_release: ir=%b a=%h want 1 20", in_ready, op_a);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid && n < 10);
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: ov=%b pending=%0d", out_valid, sb.size());
    end
    checks++;
`ifdef ALU_OPSTAGE_PERF_EN
    if (perf_stall_cnt !== 32'(stall_model) || stall_model == 0) begin
`else
    if (perf_stall_cnt !== 32'd0) begin
`endif
      errors++;
      $display("FAIL bp_stall_cnt: got %0d model %0d", perf_stall_cnt, stall_model);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b0; lane_sel = 2'b01; alu_src_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs1_a = 64'(i); rs1_b = 64'(i + 100); rs2_a = 64'(i + 200); rs2_b = 64'(i + 300);
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_rate[%0d]: ir=%b ov=%b want 1 1", i, in_ready, out_valid);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      lane_sel  = 2'($urandom_range(0, 3));
      alu_src_b = 1'($urandom_range(0, 1));
      rs1_a = {$urandom, $urandom}; rs2_a = {$urandom, $urandom};
      rs1_b = {$urandom, $urandom}; rs2_b = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid && n < 10);
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: ov=%b pending=%0d", out_valid, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; mode = 1'b1;
    rs1_a = 64'h0000_0000_0000_0A01; rs2_a = 64'h0000_0000_0000_0B01;
    @(posedge clk); #1 rs1_a = 64'h0000_0000_0000_0A02;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rs1_a = 64'h0000_0000_0000_0C03; rs2_a = 64'h0000_0000_0000_0D03;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || perf_stall_cnt !== 32'd0 || op_a !== 64'd0) begin
      errors++;
      $display("FAIL midrst_state: ov=%b ir=%b cnt=%0d a=%h", out_valid, in_ready, perf_stall_cnt, op_a);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || op_a !== 64'h0C03 || op_b !== 64'h0D03) begin
      errors++;
      $display("FAIL midrst_first: ov=%b a=%h b=%h want 1 c03 d03", out_valid, op_a, op_b);
    end
    @(negedge clk);
  endtask

  task automatic test_lanes4();
    @(posedge clk); #1;
    in_valid2 = 1'b1; out_ready2 = 1'b1; mode2 = 1'b0; lane_sel2 = 4'b0101; alu_src_b2 = 1'b0;
    rs1_a2 = 64'hA003_A002_A001_A000; rs2_a2 = 64'hC003_C002_C001_C000;
    rs1_b2 = 64'hB003_B002_B001_B000; rs2_b2 = 64'hD003_D002_D001_D000;
    @(posedge clk); #1 alu_src_b2 = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || op_a2 !== 64'hA003_B002_A001_B000 ||
        op_b2 !== 64'hC003_D002_C001_D000 || out_lane_sel2 !== 4'b0101) begin
      errors++;
      $display("FAIL lanes4_reg: ov=%b a=%h b=%h sel=%b", out_valid2, op_a2, op_b2, out_lane_sel2);
    end
    @(posedge clk); #1 in_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid2 !== 1'b1 || op_a2 !== 64'hA003_B002_A001_B000 ||
        op_b2 !== 64'hC003_D000_C001_D000) begin
      errors++;
      $display("FAIL lanes4_imm: ov=%b a=%h b=%h", out_valid2, op_a2, op_b2);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; lane_sel = 2'b00;
    alu_src_b = 1'b0; rs1_a = '0; rs2_a = '0; rs1_b = '0; rs2_b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; mode2 = 1'b0; lane_sel2 = 4'b0000;
    alu_src_b2 = 1'b0; rs1_a2 = '0; rs2_a2 = '0; rs1_b2 = '0; rs2_b2 = '0;
    test_reset();
    test_full_mode();
    test_merge();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_lanes4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
